// File: rtl/dcache_miss_handler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : dcache_miss_handler
// Description : Dcache-side miss handler. Accepts one miss at a time,
//               optionally writes back a dirty victim block, issues a block
//               read to mem_ctrl and returns the refill block to the dcache.
//               Optional macro DCMH_PERF_CTR_EN adds saturating performance
//               counters (misses, write-backs, request stall cycles).
// Revision    : 1.0 - initial release
// ============================================================================
module dcache_miss_handler #(
  parameter int BLOCK_ADDR_WIDTH = 26,
  parameter int BLOCK_DATA_WIDTH = 64
) (
  input  logic                        clk,
  input  logic                        rst_aL,
  input  logic                        miss_valid,
  input  logic [BLOCK_ADDR_WIDTH-1:0] miss_block_addr,
  input  logic                        victim_dirty,
  input  logic [BLOCK_ADDR_WIDTH-1:0] victim_block_addr,
  input  logic [BLOCK_DATA_WIDTH-1:0] victim_block_data,
  output logic                        miss_ready,
  output logic                        req_valid,
  output logic                        req_type,
  output logic [BLOCK_ADDR_WIDTH-1:0] req_block_addr,
  output logic [BLOCK_DATA_WIDTH-1:0] req_block_data,
  input  logic                        req_ready,
  input  logic                        resp_valid,
  input  logic [BLOCK_DATA_WIDTH-1:0] resp_block_data,
  output logic                        fill_valid,
  output logic [BLOCK_ADDR_WIDTH-1:0] fill_block_addr,
  output logic [BLOCK_DATA_WIDTH-1:0] fill_block_data,
  output logic                        err_unexp_resp
`ifdef DCMH_PERF_CTR_EN
  ,
  output logic [31:0]                 perf_miss_cnt,
  output logic [31:0]                 perf_wb_cnt,
  output logic [31:0]                 perf_stall_cnt
`endif
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WB_REQ  = 3'd1;
  localparam logic [2:0] S_RD_REQ  = 3'd2;
  localparam logic [2:0] S_RD_WAIT = 3'd3;
  localparam logic [2:0] S_FILL    = 3'd4;

  logic [2:0]                  state_q, state_d;
  logic [BLOCK_ADDR_WIDTH-1:0] miss_addr_q;
  logic [BLOCK_ADDR_WIDTH-1:0] victim_addr_q;
  logic [BLOCK_DATA_WIDTH-1:0] victim_data_q;
  logic [BLOCK_DATA_WIDTH-1:0] fill_data_q;
  logic                        err_q;

  logic miss_hs;
  logic req_hs;

  assign miss_hs = miss_valid && (state_q == S_IDLE);
  assign req_hs  = req_valid && req_ready;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_aL) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic: one outstanding transaction, write-back before read
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (miss_valid) state_d = victim_dirty ? S_WB_REQ : S_RD_REQ;
      S_WB_REQ:  if (req_ready)  state_d = S_RD_REQ;
      S_RD_REQ:  if (req_ready)  state_d = S_RD_WAIT;
      S_RD_WAIT: if (resp_valid) state_d = S_FILL;
      S_FILL:                    state_d = S_IDLE;
      default:                   state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state and captured registers only
  always_comb begin
    miss_ready     = 1'b0;
    req_valid      = 1'b0;
    req_type       = 1'b0;
    req_block_addr = '0;
    req_block_data = '0;
    fill_valid     = 1'b0;
    case (state_q)
      S_IDLE:   miss_ready = 1'b1;
      S_WB_REQ: begin
        req_valid      = 1'b1;
        req_type       = 1'b1;
        req_block_addr = victim_addr_q;
        req_block_data = victim_data_q;
      end
      S_RD_REQ: begin
        req_valid      = 1'b1;
        req_block_addr = miss_addr_q;
      end
      S_FILL:   fill_valid = 1'b1;
      default:  ;
    endcase
  end

  assign fill_block_addr = miss_addr_q;
  assign fill_block_data = fill_data_q;
  assign err_unexp_resp  = err_q;

  // Capture miss/victim info on accept and read data on the expected response
  always_ff @(posedge clk) begin
    if (!rst_aL) begin
      miss_addr_q   <= '0;
      victim_addr_q <= '0;
      victim_data_q <= '0;
      fill_data_q   <= '0;
    end else begin
      if (miss_hs) begin
        miss_addr_q   <= miss_block_addr;
        victim_addr_q <= victim_block_addr;
        victim_data_q <= victim_block_data;
      end
      if (resp_valid && (state_q == S_RD_WAIT)) begin
        fill_data_q <= resp_block_data;
      end
    end
  end

  // Sticky error: any response outside RD_WAIT (incl. same cycle as read accept)
  always_ff @(posedge clk) begin
    if (!rst_aL)                                 err_q <= 1'b0;
    else if (resp_valid && (state_q != S_RD_WAIT)) err_q <= 1'b1;
  end

`ifdef DCMH_PERF_CTR_EN
  logic [31:0] miss_cnt_q, wb_cnt_q, stall_cnt_q;

  // Saturating event counters
  always_ff @(posedge clk) begin
    if (!rst_aL) begin
      miss_cnt_q  <= '0;
      wb_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (miss_hs && (miss_cnt_q != 32'hFFFF_FFFF))
        miss_cnt_q <= miss_cnt_q + 32'd1;
      if (req_hs && req_type && (wb_cnt_q != 32'hFFFF_FFFF))
        wb_cnt_q <= wb_cnt_q + 32'd1;
      if (req_valid && !req_ready && (stall_cnt_q != 32'hFFFF_FFFF))
        stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign perf_miss_cnt  = miss_cnt_q;
  assign perf_wb_cnt    = wb_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`else
  logic unused_req_hs;
  assign unused_req_hs = req_hs;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dcache_miss_handler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_dcache_miss_handler
// Description : Self-checking bench for dcache_miss_handler. Each miss is
//               turned into an expected list of memory requests plus a fill;
//               a small model tracks the sticky error and event counts.
//               Honours DCMH_PERF_CTR_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dcache_miss_handler;

  logic        clk = 1'b0;
  logic        rst_aL;
  logic        miss_valid;
  logic [25:0] miss_block_addr;
  logic        victim_dirty;
  logic [25:0] victim_block_addr;
  logic [63:0] victim_block_data;
  logic        miss_ready;
  logic        req_valid;
  logic        req_type;
  logic [25:0] req_block_addr;
  logic [63:0] req_block_data;
  logic        req_ready;
  logic        resp_valid;
  logic [63:0] resp_block_data;
  logic        fill_valid;
  logic [25:0] fill_block_addr;
  logic [63:0] fill_block_data;
  logic        err_unexp_resp;
`ifdef DCMH_PERF_CTR_EN
  logic [31:0] perf_miss_cnt, perf_wb_cnt, perf_stall_cnt;
`endif

  dcache_miss_handler #(.BLOCK_ADDR_WIDTH(26), .BLOCK_DATA_WIDTH(64)) dut (
    .clk               (clk),
    .rst_aL            (rst_aL),
    .miss_valid        (miss_valid),
    .miss_block_addr   (miss_block_addr),
    .victim_dirty      (victim_dirty),
    .victim_block_addr (victim_block_addr),
    .victim_block_data (victim_block_data),
    .miss_ready        (miss_ready),
    .req_valid         (req_valid),
    .req_type          (req_type),
    .req_block_addr    (req_block_addr),
    .req_block_data    (req_block_data),
    .req_ready         (req_ready),
    .resp_valid        (resp_valid),
    .resp_block_data   (resp_block_data),
    .fill_valid        (fill_valid),
    .fill_block_addr   (fill_block_addr),
    .fill_block_data   (fill_block_data),
    .err_unexp_resp    (err_unexp_resp)
`ifdef DCMH_PERF_CTR_EN
    ,
    .perf_miss_cnt     (perf_miss_cnt),
    .perf_wb_cnt       (perf_wb_cnt),
    .perf_stall_cnt    (perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          wr;
    logic [25:0] addr;
    logic [63:0] data;
    int          stall;
  } req_t;

  int n_cmp = 0;
  int n_err = 0;

  // Reference state
  bit          m_err;
  int unsigned m_miss, m_wb, m_stall;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_err = 1'b0; m_miss = 0; m_wb = 0; m_stall = 0;
  endtask

  task automatic chk_perf(input string tag);
`ifdef DCMH_PERF_CTR_EN
    chk({tag, "_perf_miss"},  perf_miss_cnt,  m_miss);
    chk({tag, "_perf_wb"},    perf_wb_cnt,    m_wb);
    chk({tag, "_perf_stall"}, perf_stall_cnt, m_stall);
`else
    chk({tag, "_err"}, err_unexp_resp, m_err);
`endif
  endtask

  function automatic logic [25:0] rnd_addr();
    return 26'($urandom);
  endfunction

  function automatic logic [63:0] rnd_data();
    return {$urandom, $urandom};
  endfunction

  // One complete miss; entered and left at a negedge with the handler idle.
  task automatic run_miss(input logic [25:0] maddr, input bit dirty,
                          input logic [25:0] vaddr, input logic [63:0] vdata,
                          input int wb_stall, input int rd_stall, input int lat,
                          input logic [63:0] rdata);
    req_t q[$];
    req_t r;
    chk("idle_miss_ready", miss_ready, 1'b1);
    chk("idle_req_valid",  req_valid,  1'b0);
    chk("idle_fill_valid", fill_valid, 1'b0);
    miss_valid        = 1'b1;
    miss_block_addr   = maddr;
    victim_dirty      = dirty;
    victim_block_addr = vaddr;
    victim_block_data = vdata;
    req_ready         = 1'b0;
    m_miss++;
    if (dirty) begin
      r.wr = 1'b1; r.addr = vaddr; r.data = vdata; r.stall = wb_stall;
      q.push_back(r);
      m_wb++;
      m_stall += wb_stall;
    end
    r.wr = 1'b0; r.addr = maddr; r.data = 64'd0; r.stall = rd_stall;
    q.push_back(r);
    m_stall += rd_stall;
    @(negedge clk);
    // Scramble inputs: the handler must work from its captured copy
    miss_valid        = 1'b0;
    miss_block_addr   = rnd_addr();
    victim_dirty      = $urandom_range(0, 1) != 0;
    victim_block_addr = rnd_addr();
    victim_block_data = rnd_data();
    chk("busy_miss_ready", miss_ready, 1'b0);
    while (q.size() > 0) begin
      r = q.pop_front();
      for (int k = 0; k <= r.stall; k++) begin
        chk("req_valid", req_valid,      1'b1);
        chk("req_type",  req_type,       r.wr);
        chk("req_addr",  req_block_addr, r.addr);
        chk("req_data",  req_block_data, r.data);
        chk("req_fill",  fill_valid,     1'b0);
        req_ready = (k == r.stall);
        @(negedge clk);
        req_ready = 1'b0;
      end
    end
    for (int i = 0; i < lat - 1; i++) begin
      chk("wait_req_valid",  req_valid,  1'b0);
      chk("wait_fill_valid", fill_valid, 1'b0);
      @(negedge clk);
    end
    chk("wait_req_valid", req_valid, 1'b0);
    resp_valid      = 1'b1;
    resp_block_data = rdata;
    @(negedge clk);
    resp_valid      = 1'b0;
    resp_block_data = rnd_data();
    chk("fill_valid",      fill_valid,      1'b1);
    chk("fill_addr",       fill_block_addr, maddr);
    chk("fill_data",       fill_block_data, rdata);
    chk("fill_miss_ready", miss_ready,      1'b0);
    chk("fill_err",        err_unexp_resp,  m_err);
    @(negedge clk);
    chk("post_fill_valid", fill_valid, 1'b0);
    chk("post_fill_ready", miss_ready, 1'b1);
  endtask

  initial begin
    logic [25:0] a;
    bit          d;
    model_reset();
    rst_aL            = 1'b0;
    miss_valid        = 1'b0;
    miss_block_addr   = '0;
    victim_dirty      = 1'b0;
    victim_block_addr = '0;
    victim_block_data = '0;
    req_ready         = 1'b0;
    resp_valid        = 1'b0;
    resp_block_data   = '0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_miss_ready", miss_ready,      1'b1);
    chk("rst_req_valid",  req_valid,       1'b0);
    chk("rst_req_type",   req_type,        1'b0);
    chk("rst_req_addr",   req_block_addr,  26'd0);
    chk("rst_req_data",   req_block_data,  64'd0);
    chk("rst_fill_valid", fill_valid,      1'b0);
    chk("rst_fill_addr",  fill_block_addr, 26'd0);
    chk("rst_fill_data",  fill_block_data, 64'd0);
    chk("rst_err",        err_unexp_resp,  1'b0);
    chk_perf("rst");
    rst_aL = 1'b1;
    @(negedge clk);

    // Clean miss, memory latency 3
    run_miss(26'h0001234, 1'b0, 26'h3FF_FFFF, 64'h1111, 0, 0, 3, 64'hDEAD_BEEF_0000_0001);
    // Dirty miss: write-back then read
    run_miss(26'h0000080, 1'b1, 26'h0000040, 64'hA5A5, 0, 0, $urandom_range(1, 4), rnd_data());
    chk_perf("basic");

    // Write request stalled 5 cycles, read stalled randomly
    begin
      int unsigned s0;
      s0 = m_stall;
      run_miss(rnd_addr(), 1'b1, rnd_addr(), rnd_data(), 5, 0, 2, rnd_data());
      chk("wb_stall_delta", m_stall - s0, 5);
      run_miss(rnd_addr(), 1'b0, rnd_addr(), rnd_data(), 0, $urandom_range(1, 4), 1, rnd_data());
      chk_perf("stall");
    end

    // 10 back-to-back misses, 4 of them dirty
    begin
      int unsigned m0, w0;
      m0 = m_miss; w0 = m_wb;
      for (int i = 0; i < 10; i++) begin
        d = (i == 1) || (i == 4) || (i == 5) || (i == 9);
        a = rnd_addr();
        run_miss(a, d, rnd_addr(), rnd_data(), $urandom_range(0, 2), $urandom_range(0, 2),
                 $urandom_range(1, 5), rnd_data());
      end
      chk("b2b_miss_delta", m_miss - m0, 10);
      chk("b2b_wb_delta",   m_wb - w0,   4);
      chk_perf("b2b");
    end

    // Stray response while idle
    resp_valid      = 1'b1;
    resp_block_data = rnd_data();
    @(negedge clk);
    resp_valid = 1'b0;
    m_err      = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("stray_fill_valid", fill_valid,     1'b0);
      chk("stray_err",        err_unexp_resp, m_err);
      chk("stray_miss_ready", miss_ready,     1'b1);
      @(negedge clk);
    end
    // Handler still works with error flagged
    run_miss(rnd_addr(), 1'b1, rnd_addr(), rnd_data(), 1, 1, 2, rnd_data());
    chk_perf("stray");

    // Reset during RD_WAIT, then the abandoned response arrives
    miss_valid      = 1'b1;
    miss_block_addr = rnd_addr();
    victim_dirty    = 1'b0;
    req_ready       = 1'b1;
    @(negedge clk);
    miss_valid = 1'b0;
    chk("rw_req_valid", req_valid, 1'b1);
    chk("rw_req_type",  req_type,  1'b0);
    @(negedge clk);
    req_ready = 1'b0;
    chk("rw_wait_req_valid", req_valid, 1'b0);
    rst_aL = 1'b0;
    @(negedge clk);
    rst_aL = 1'b1;
    model_reset();
    chk("rw_rst_miss_ready", miss_ready,     1'b1);
    chk("rw_rst_req_valid",  req_valid,      1'b0);
    chk("rw_rst_err",        err_unexp_resp, m_err);
    resp_valid      = 1'b1;
    resp_block_data = rnd_data();
    @(negedge clk);
    resp_valid = 1'b0;
    m_err      = 1'b1;
    chk("rw_fill_valid", fill_valid,     1'b0);
    chk("rw_req_valid2", req_valid,      1'b0);
    chk("rw_err",        err_unexp_resp, m_err);
    chk("rw_miss_ready", miss_ready,     1'b1);
    @(negedge clk);
    chk("rw_fill_valid2", fill_valid, 1'b0);
    chk_perf("rw");

    // Recovery after reset
    run_miss(rnd_addr(), 1'b0, rnd_addr(), rnd_data(), 0, 0, 3, rnd_data());
    chk_perf("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
